// File: rtl/jtag_hub_pkg.sv
// Shared definitions for the JTAG chain hub: status bit offsets, DR length helper.
// Optional parity feature selected by defining JTAG_HUB_PARITY_EN.
package jtag_hub_pkg;

  localparam int unsigned MAX_CHAINS = 8;

  // Status bit offsets, counted from the first bit above the payload.
  localparam int unsigned STAT_RSP_FULL = 0;
  localparam int unsigned STAT_OVF      = 1;
  localparam int unsigned STAT_PERR     = 2;

`ifdef JTAG_HUB_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Total DR length: payload, rsp_full, ovf and (optionally) parity/perr.
  function automatic int unsigned dr_len(input int unsigned data_width);
    return data_width + 2 + (PARITY_EN ? 1 : 0);
  endfunction

endpackage

// File: rtl/jtag_hub_chain.sv
// One JTAG user data register: shift register, command register, response buffer, flags.
// Parity checking and the perr flag exist only when JTAG_HUB_PARITY_EN is defined.
module jtag_hub_chain
  import jtag_hub_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic                  shift_i,
  input  logic                  tdi_i,
  input  logic                  upd_i,
  output logic                  tdo_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [DATA_WIDTH-1:0] cmd_data_o,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic [DATA_WIDTH-1:0] rsp_data_i
);

  localparam int unsigned DrLen = dr_len(DATA_WIDTH);

  logic [DrLen-1:0]      sr_q, sr_d;
  logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] rsp_q, rsp_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  rsp_full_q, rsp_full_d;
  logic                  ovf_q, ovf_d;
  logic                  upd_ok;
  logic [DrLen-1:0]      cap_word;
`ifdef JTAG_HUB_PARITY_EN
  logic                  perr_q, perr_d;
  logic                  par_bad;
`endif

  // Next-state for capture/shift, response buffering and command handoff.
  always_comb begin
    sr_d        = sr_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    cmd_valid_d = cmd_valid_q;
    rsp_full_d  = rsp_full_q;
    ovf_d       = ovf_q;
`ifdef JTAG_HUB_PARITY_EN
    perr_d   = perr_q;
    par_bad  = ^{sr_q[DrLen-1], sr_q[DATA_WIDTH-1:0]};
    upd_ok   = upd_i & ~par_bad;
    cap_word = {perr_q, ovf_q, rsp_full_q, rsp_q};
`else
    upd_ok   = upd_i;
    cap_word = {ovf_q, rsp_full_q, rsp_q};
`endif

    if (ce_i) begin
      if (shift_i) begin
        sr_d = {tdi_i, sr_q[DrLen-1:1]};
      end else begin
        sr_d       = cap_word;
        rsp_full_d = 1'b0;
        ovf_d      = 1'b0;
`ifdef JTAG_HUB_PARITY_EN
        perr_d     = 1'b0;
`endif
      end
    end

    // A response landing in the capture cycle survives: capture already took the old word.
    if (rsp_valid_i && !rsp_full_q) begin
      rsp_d      = rsp_data_i;
      rsp_full_d = 1'b1;
    end

`ifdef JTAG_HUB_PARITY_EN
    if (upd_i && par_bad) begin
      perr_d = 1'b1;
    end
`endif

    if (upd_ok && (!cmd_valid_q || cmd_ready_i)) begin
      cmd_d       = sr_q[DATA_WIDTH-1:0];
      cmd_valid_d = 1'b1;
    end else begin
      if (upd_ok) begin
        ovf_d = 1'b1;
      end
      if (cmd_valid_q && cmd_ready_i) begin
        cmd_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q        <= '0;
      cmd_q       <= '0;
      rsp_q       <= '0;
      cmd_valid_q <= 1'b0;
      rsp_full_q  <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef JTAG_HUB_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      sr_q        <= sr_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      cmd_valid_q <= cmd_valid_d;
      rsp_full_q  <= rsp_full_d;
      ovf_q       <= ovf_d;
`ifdef JTAG_HUB_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  assign tdo_o       = sr_q[0];
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_data_o  = cmd_q;
  assign rsp_ready_o = ~rsp_full_q;

endmodule

// File: rtl/jtag_chain_hub.sv
// JTAG chain hub top: lowest-index chain select, update routing, run-test-idle commit pulses.
// Optional DR parity bit enabled by defining JTAG_HUB_PARITY_EN.
module jtag_chain_hub
  import jtag_hub_pkg::*;
#(
  parameter int unsigned NUM_CHAINS = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             JTCK,
  input  logic                             JRST,
  input  logic                             JTDI,
  input  logic                             JSHIFT,
  input  logic                             JUPDATE,
  input  logic [NUM_CHAINS-1:0]            JCE,
  input  logic [NUM_CHAINS-1:0]            JRTI,
  output logic [NUM_CHAINS-1:0]            JTDO,
  output logic [NUM_CHAINS-1:0]            cmd_valid,
  input  logic [NUM_CHAINS-1:0]            cmd_ready,
  output logic [NUM_CHAINS*DATA_WIDTH-1:0] cmd_data,
  input  logic [NUM_CHAINS-1:0]            rsp_valid,
  output logic [NUM_CHAINS-1:0]            rsp_ready,
  input  logic [NUM_CHAINS*DATA_WIDTH-1:0] rsp_data,
  output logic [NUM_CHAINS-1:0]            cmd_commit
);

  localparam int unsigned SelW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

  logic [SelW-1:0]       act_idx;
  logic [NUM_CHAINS-1:0] ce_act;
  logic                  seen;
  logic [NUM_CHAINS-1:0] upd_vec;

  logic [SelW-1:0]       sel_q, sel_d;
  logic                  sel_vld_q, sel_vld_d;
  logic [NUM_CHAINS-1:0] jrti_q, jrti_d;
  logic [NUM_CHAINS-1:0] commit_q, commit_d;

  // Priority select: only the lowest enabled chain captures or shifts.
  always_comb begin
    act_idx = '0;
    ce_act  = '0;
    seen    = 1'b0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (JCE[i] && !seen) begin
        ce_act[i] = 1'b1;
        act_idx   = SelW'(i);
        seen      = 1'b1;
      end
    end
  end

  // Next-state for the selected-chain record and run-test-idle edge detect.
  always_comb begin
    sel_d     = seen ? act_idx : sel_q;
    sel_vld_d = sel_vld_q | seen;
    jrti_d    = JRTI;
    commit_d  = JRTI & ~jrti_q;
  end

  // Hub-level registers with synchronous reset.
  always_ff @(posedge JTCK) begin
    if (JRST) begin
      sel_q     <= '0;
      sel_vld_q <= 1'b0;
      jrti_q    <= '0;
      commit_q  <= '0;
    end else begin
      sel_q     <= sel_d;
      sel_vld_q <= sel_vld_d;
      jrti_q    <= jrti_d;
      commit_q  <= commit_d;
    end
  end

  assign cmd_commit = commit_q;

  for (genvar i = 0; i < NUM_CHAINS; i++) begin : g_chain
    // Update goes only to the last selected chain, and never before any selection.
    assign upd_vec[i] = JUPDATE & sel_vld_q & (sel_q == SelW'(i));

    jtag_hub_chain #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_chain (
      .clk_i       (JTCK),
      .rst_i       (JRST),
      .ce_i        (ce_act[i]),
      .shift_i     (JSHIFT),
      .tdi_i       (JTDI),
      .upd_i       (upd_vec[i]),
      .tdo_o       (JTDO[i]),
      .cmd_valid_o (cmd_valid[i]),
      .cmd_ready_i (cmd_ready[i]),
      .cmd_data_o  (cmd_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .rsp_valid_i (rsp_valid[i]),
      .rsp_ready_o (rsp_ready[i]),
      .rsp_data_i  (rsp_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
